// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/DATA frames into instruction-memory writes.
// Optional trailing checksum byte is compiled in with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int          ADDR_W    = 7,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_address,
  output logic [7:0]        inst_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, FIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   wa_reg, wa_next;
  logic [7:0]          wd_reg, wd_next;
  logic                hold_reg, hold_next;
  logic                err_reg, err_next;
  logic                beat;
  logic [7:0]          addr_hi;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_reg, csum_next;
  logic [7:0]          csum_sum;
  assign csum_sum = csum_reg + s_data;
`endif

  // s_ready is gated by rst so it drops the instant reset asserts
  assign s_ready      = !rst && (state_reg != FIN);
  assign beat         = s_valid && s_ready;
  assign addr_hi      = s_data >> ADDR_W;
  assign inst_we      = we_reg;
  assign inst_address = wa_reg;
  assign inst_data    = wd_reg;
  assign cpu_hold     = hold_reg;
  assign err          = err_reg;
  assign done         = (state_reg == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      wa_reg    <= '0;
      wd_reg    <= '0;
      hold_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      wa_reg    <= wa_next;
      wd_reg    <= wd_next;
      hold_reg  <= hold_next;
      err_reg   <= err_next;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    we_next    = 1'b0;
    wa_next    = wa_reg;
    wd_next    = wd_reg;
    hold_next  = hold_reg;
    err_next   = err_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (beat && s_data == SYNC_BYTE) begin
          state_next = ADDR;
          err_next   = 1'b0;
        end
      end
      ADDR: begin
        if (beat) begin
          hold_next = 1'b1;
          addr_next = s_data[ADDR_W-1:0];
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_next = s_data;
`endif
          if (addr_hi != 8'h00) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = LEN;
          end
        end
      end
      LEN: begin
        if (beat) begin
          cnt_next = s_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_next = csum_sum;
`endif
          if (s_data == 8'h00) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (beat) begin
          we_next   = 1'b1;
          wa_next   = addr_reg;
          wd_next   = s_data;
          addr_next = addr_reg + 1'b1;
          cnt_next  = cnt_reg - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_next = csum_sum;
          if (cnt_reg == 8'd1) state_next = CSUM;
`else
          if (cnt_reg == 8'd1) begin
            state_next = FIN;
            hold_next  = 1'b0;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (beat) begin
          if (csum_sum == 8'h00) begin
            state_next = FIN;
            hold_next  = 1'b0;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Table-driven bench for prog_loader; covers both builds of PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready, inst_we, cpu_hold, done, err;
  logic [AW-1:0] inst_address;
  logic [7:0]    inst_data;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .inst_we(inst_we), .inst_address(inst_address), .inst_data(inst_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  typedef struct packed {
    logic          rdy;
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          hold;
    logic          dn;
    logic          er;
  } out_t;

  typedef struct {
    string      name;
    logic       r;
    logic       v;
    logic [7:0] din;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic add(input string name, input logic r, input logic v, input logic [7:0] din,
                     input logic rdy, input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                     input logic hold, input logic dn, input logic er);
    vec_t x;
    x.name = name; x.r = r; x.v = v; x.din = din;
    x.exp.rdy = rdy; x.exp.we = we; x.exp.a = a; x.exp.d = d;
    x.exp.hold = hold; x.exp.dn = dn; x.exp.er = er;
    tbl.push_back(x);
  endtask

  function automatic out_t sample();
    out_t o;
    o.rdy = s_ready; o.we = inst_we; o.a = inst_address; o.d = inst_data;
    o.hold = cpu_hold; o.dn = done; o.er = err;
    return o;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, got, exp);
  endtask

  // Stream with idle gaps: A5,7D,04 + 4 payload bytes (one equal to SYNC) [+ checksum]
  task automatic gap_frame();
    logic [7:0]    pay[4];
    logic [7:0]    bytes[$];
    logic [7:0]    sum;
    logic [AW-1:0] wa[$];
    logic [7:0]    wd[$];
    logic [AW-1:0] ea;
    int            idx;
    bit            got_done;
    bit            beat;
    pay = '{8'h31, 8'hA5, 8'hC3, 8'hD4};
    bytes = {8'hA5, 8'h7D, 8'h04};
    sum = 8'h7D + 8'h04;
    for (int i = 0; i < 4; i++) begin
      bytes.push_back(pay[i]);
      sum = sum + pay[i];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    bytes.push_back(8'h00 - sum);
`endif
    idx = 0;
    got_done = 0;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      @(negedge clk);
      rst     = 1'b0;
      s_valid = (idx < bytes.size()) && (cyc % 3 != 2);
      s_data  = (idx < bytes.size()) ? bytes[idx] : 8'h00;
      #1;
      if (inst_we) begin
        wa.push_back(inst_address);
        wd.push_back(inst_data);
      end
      if (done) begin
        got_done = 1;
        check_bit("gap_err_at_done", err, 1'b0);
        check_bit("gap_hold_at_done", cpu_hold, 1'b0);
      end
      beat = s_valid && s_ready;
      @(posedge clk);
      if (beat) idx++;
    end
    s_valid = 1'b0;
    total_cnt++;
    if (got_done) pass_cnt++;
    else $display("FAIL gap_done_timeout: no done within 100 cycles, expected done");
    total_cnt++;
    if (wa.size() == 4) pass_cnt++;
    else $display("FAIL gap_write_count: got %0d writes, expected 4", wa.size());
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      ea = AW'(7'h7D + i);
      total_cnt++;
      if (wa[i] === ea && wd[i] === pay[i]) pass_cnt++;
      else $display("FAIL gap_write[%0d]: got (%h,%h), expected (%h,%h)", i, wa[i], wd[i], ea, pay[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t got;

    // ---- bad address byte, zero length, resync ----
    add("reset",     1, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("ign_00",    0, 1, 8'h00, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("ign_ff",    0, 1, 8'hFF, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("sync",      0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("badaddr",   0, 1, 8'h80, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("badaddr_e", 0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 1);
    add("sync2",     0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 1, 0, 1);
    add("addr00",    0, 1, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("len0",      0, 1, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("len0_e",    0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 1);
    add("idle_acc",  0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 1, 0, 1);
    add("idle_clr",  0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 0);
`ifndef PROG_LOADER_CHECKSUM_EN
    // ---- good frame, no checksum ----
    add("reset",     1, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("f_sync",    0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("f_addr",    0, 1, 8'h10, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("f_len",     0, 1, 8'h03, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("f_d0",      0, 1, 8'h11, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("f_d1",      0, 1, 8'h22, 1, 1, 7'h10, 8'h11, 1, 0, 0);
    add("f_d2",      0, 1, 8'h33, 1, 1, 7'h11, 8'h22, 1, 0, 0);
    add("f_fin",     0, 0, 8'h00, 0, 1, 7'h12, 8'h33, 0, 1, 0);
    add("f_idle",    0, 0, 8'h00, 1, 0, 7'h12, 8'h33, 0, 0, 0);
`else
    // ---- good checksum frame with address wrap, then bad checksum ----
    add("reset",     1, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("c_sync",    0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("c_addr",    0, 1, 8'h7E, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("c_len",     0, 1, 8'h03, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("c_d0",      0, 1, 8'h01, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("c_d1",      0, 1, 8'h02, 1, 1, 7'h7E, 8'h01, 1, 0, 0);
    add("c_d2",      0, 1, 8'h03, 1, 1, 7'h7F, 8'h02, 1, 0, 0);
    add("c_csum",    0, 1, 8'h79, 1, 1, 7'h00, 8'h03, 1, 0, 0);
    add("c_fin",     0, 0, 8'h00, 0, 0, 7'h00, 8'h03, 0, 1, 0);
    add("c_idle",    0, 0, 8'h00, 1, 0, 7'h00, 8'h03, 0, 0, 0);
    add("b_sync",    0, 1, 8'hA5, 1, 0, 7'h00, 8'h03, 0, 0, 0);
    add("b_addr",    0, 1, 8'h7E, 1, 0, 7'h00, 8'h03, 0, 0, 0);
    add("b_len",     0, 1, 8'h03, 1, 0, 7'h00, 8'h03, 1, 0, 0);
    add("b_d0",      0, 1, 8'h01, 1, 0, 7'h00, 8'h03, 1, 0, 0);
    add("b_d1",      0, 1, 8'h02, 1, 1, 7'h7E, 8'h01, 1, 0, 0);
    add("b_d2",      0, 1, 8'h03, 1, 1, 7'h7F, 8'h02, 1, 0, 0);
    add("b_csum",    0, 1, 8'h7B, 1, 1, 7'h00, 8'h03, 1, 0, 0);
    add("b_err",     0, 0, 8'h00, 1, 0, 7'h00, 8'h03, 1, 0, 1);
    add("b_resync",  0, 1, 8'hA5, 1, 0, 7'h00, 8'h03, 1, 0, 1);
    add("b_clr",     0, 0, 8'h00, 1, 0, 7'h00, 8'h03, 1, 0, 0);
`endif
    // ---- toggling s_valid, reset asserted mid-DATA ----
    add("reset",     1, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_sync",    0, 1, 8'hA5, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_gap0",    0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_addr",    0, 1, 8'h00, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_gap1",    0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("t_len",     0, 1, 8'h02, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("t_gap2",    0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("t_d0",      0, 1, 8'hAA, 1, 0, 7'h00, 8'h00, 1, 0, 0);
    add("t_wr",      0, 0, 8'h00, 1, 1, 7'h00, 8'hAA, 1, 0, 0);
    add("t_rst_async", 1, 1, 8'hBB, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_rst_hold",  1, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_post0",   0, 1, 8'hBB, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_post1",   0, 1, 8'hBB, 1, 0, 7'h00, 8'h00, 0, 0, 0);
    add("t_post2",   0, 0, 8'h00, 1, 0, 7'h00, 8'h00, 0, 0, 0);

    // Inputs change on the falling edge; outputs for that cycle are checked 1 ns later.
    foreach (tbl[i]) begin
      @(negedge clk);
      rst     = tbl[i].r;
      s_valid = tbl[i].v;
      s_data  = tbl[i].din;
      #1;
      got = sample();
      total_cnt++;
      if (got === tbl[i].exp) pass_cnt++;
      else $display("FAIL %s[%0d]: got rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, expected rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b",
                    tbl[i].name, i, got.rdy, got.we, got.a, got.d, got.hold, got.dn, got.er,
                    tbl[i].exp.rdy, tbl[i].exp.we, tbl[i].exp.a, tbl[i].exp.d,
                    tbl[i].exp.hold, tbl[i].exp.dn, tbl[i].exp.er);
    end

    gap_frame();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
